// File: rtl/gray_monitor.sv
// Watches a 3-bit Gray counter stream: converts to binary, counts wraps and
// flags any transition a well-behaved Gray counter could not have produced.
module gray_monitor (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Valid,
    input  logic [2:0] Gray,
    input  logic       Clr,
    output logic [2:0] Bin,
    output logic [7:0] Laps,
    output logic       Locked,
    output logic       Step_err,
    output logic       Err_sticky
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [2:0] prev_r;
    logic [2:0] prev_s;
    logic [2:0] bin_r;
    logic [2:0] bin_s;
    logic [7:0] laps_r;
    logic [7:0] laps_s;
    logic       locked_r;
    logic       step_err_r;
    logic       step_err_s;
    logic       err_sticky_r;
    logic       err_sticky_s;

    logic [2:0] sample_bin_s;
    logic [2:0] step_gray_s;
    logic       hold_s;
    logic       step_s;
    logic       wrap_s;
    logic       restart_s;
    logic       legal_s;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return b ^ {1'b0, b[2:1]};
    endfunction

    // Classify the incoming sample against the previously accepted one
    always_comb begin
        sample_bin_s = gray2bin(Gray);
        step_gray_s  = bin2gray(gray2bin(prev_r) + 3'd1);
        hold_s       = (Gray == prev_r);
        step_s       = (Gray == step_gray_s);
        wrap_s       = (prev_r == 3'b100) && (Gray == 3'b000);
        restart_s    = (Gray == 3'b000) && (prev_r != 3'b100);
        legal_s      = hold_s || step_s || wrap_s || restart_s;
    end

    // Next-state and next-output computation; Clr outranks any sample
    always_comb begin
        state_s      = state_r;
        prev_s       = prev_r;
        bin_s        = bin_r;
        laps_s       = laps_r;
        step_err_s   = 1'b0;
        err_sticky_s = err_sticky_r;
        if (Clr) begin
            err_sticky_s = 1'b0;
            state_s      = ST_UNLOCKED;
        end else if (Valid) begin
            prev_s = Gray;
            bin_s  = sample_bin_s;
            case (state_r)
                ST_UNLOCKED: begin
                    state_s = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (wrap_s) begin
                        laps_s = laps_r + 8'd1;
                    end else begin
                        laps_s = laps_r;
                    end
                    if (legal_s) begin
                        state_s = ST_LOCKED;
                    end else begin
                        step_err_s   = 1'b1;
                        err_sticky_s = 1'b1;
                        state_s      = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    state_s = ST_FAULT;
                end
                default: begin
                    state_s = ST_UNLOCKED;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_UNLOCKED;
            prev_r       <= 3'b000;
            bin_r        <= 3'b000;
            laps_r       <= 8'd0;
            locked_r     <= 1'b0;
            step_err_r   <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            prev_r       <= prev_s;
            bin_r        <= bin_s;
            laps_r       <= laps_s;
            locked_r     <= (state_s == ST_LOCKED);
            step_err_r   <= step_err_s;
            err_sticky_r <= err_sticky_s;
        end
    end

    assign Bin        = bin_r;
    assign Laps       = laps_r;
    assign Locked     = locked_r;
    assign Step_err   = step_err_r;
    assign Err_sticky = err_sticky_r;

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor: a sequence-position model checked every
// cycle, plus hand-computed checkpoints for each scenario.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Valid = 1'b0;
    logic [2:0] Gray = 3'b000;
    logic       Clr = 1'b0;
    logic [2:0] Bin;
    logic [7:0] Laps;
    logic       Locked;
    logic       Step_err;
    logic       Err_sticky;

    int n_checks = 0;
    int n_fail = 0;

    // Counting order of a 3-bit Gray counter; position in this list is the binary value
    int gseq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    typedef struct {
        int st;      // 0 unlocked, 1 locked, 2 fault
        int p;
        int bin;
        int laps;
        int step;
        int sticky;
    } model_t;

    model_t m = '{0, 0, 0, 0, 0, 0};

    gray_monitor dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Valid      (Valid),
        .Gray       (Gray),
        .Clr        (Clr),
        .Bin        (Bin),
        .Laps       (Laps),
        .Locked     (Locked),
        .Step_err   (Step_err),
        .Err_sticky (Err_sticky)
    );

    initial forever #5 Clk = ~Clk;

    function automatic int pos(input int g);
        for (int i = 0; i < 8; i++) begin
            if (gseq[i] == g) return i;
        end
        return 0;
    endfunction

    function automatic model_t model_next(input model_t cur, input logic v,
                                          input int g, input logic c);
        model_t n;
        int d;
        n = cur;
        n.step = 0;
        if (c) begin
            n.sticky = 0;
            n.st = 0;
        end else if (v) begin
            if (cur.st == 1) begin
                d = (pos(g) - pos(cur.p) + 8) % 8;
                if (cur.p == 4 && g == 0) n.laps = (cur.laps + 1) % 256;
                if (!(g == cur.p || d == 1 || g == 0)) begin
                    n.step = 1;
                    n.sticky = 1;
                    n.st = 2;
                end
            end else if (cur.st == 0) begin
                n.st = 1;
            end
            n.p = g;
            n.bin = pos(g);
        end
        return n;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m <= '{0, 0, 0, 0, 0, 0};
        else        m <= model_next(m, Valid, int'(Gray), Clr);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge Clk) begin
        chk("bin", int'(Bin), m.bin);
        chk("laps", int'(Laps), m.laps);
        chk("locked", int'(Locked), (m.st == 1) ? 1 : 0);
        chk("step_err", int'(Step_err), m.step);
        chk("err_sticky", int'(Err_sticky), m.sticky);
    end

    task automatic drive(input logic v, input logic [2:0] g, input logic c);
        @(negedge Clk);
        Valid = v;
        Gray  = g;
        Clr   = c;
    endtask

    task automatic after_edge();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1 Reset = 1'b0;
        #2;
        chk("rst_bin", int'(Bin), 0);
        chk("rst_laps", int'(Laps), 0);
        chk("rst_locked", int'(Locked), 0);
        chk("rst_sticky", int'(Err_sticky), 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Normal count through one full lap
        drive(1'b1, 3'b000, 1'b0);
        after_edge();
        chk("lock_first", int'(Locked), 1);
        for (int k = 1; k < 8; k++) drive(1'b1, 3'(gseq[k]), 1'b0);
        after_edge();
        chk("count_bin7", int'(Bin), 7);
        drive(1'b1, 3'b000, 1'b0);
        after_edge();
        chk("count_bin0", int'(Bin), 0);
        chk("count_laps", int'(Laps), 1);
        chk("count_locked", int'(Locked), 1);

        // Hold with Valid toggling
        drive(1'b1, 3'b001, 1'b0);
        drive(1'b1, 3'b011, 1'b0);
        drive(1'b0, 3'b011, 1'b0);
        drive(1'b1, 3'b011, 1'b0);
        drive(1'b0, 3'b011, 1'b0);
        after_edge();
        chk("hold_bin", int'(Bin), 2);
        chk("hold_laps", int'(Laps), 1);
        chk("hold_sticky", int'(Err_sticky), 0);

        // Restart from 110
        drive(1'b1, 3'b010, 1'b0);
        drive(1'b1, 3'b110, 1'b0);
        drive(1'b1, 3'b000, 1'b0);
        after_edge();
        chk("restart_bin", int'(Bin), 0);
        chk("restart_laps", int'(Laps), 1);
        chk("restart_err", int'(Err_sticky), 0);

        // Illegal jump 001 -> 110
        drive(1'b1, 3'b001, 1'b0);
        drive(1'b1, 3'b110, 1'b0);
        after_edge();
        chk("illegal_step", int'(Step_err), 1);
        chk("illegal_sticky", int'(Err_sticky), 1);
        chk("illegal_locked", int'(Locked), 0);
        chk("illegal_bin", int'(Bin), 4);
        drive(1'b1, 3'b011, 1'b0);
        after_edge();
        chk("fault_no_step", int'(Step_err), 0);
        chk("fault_sticky", int'(Err_sticky), 1);
        drive(1'b1, 3'b101, 1'b0);
        after_edge();
        chk("fault_bin", int'(Bin), 6);

        // Clr wins over a simultaneous sample
        drive(1'b1, 3'b011, 1'b1);
        after_edge();
        chk("clr_sticky", int'(Err_sticky), 0);
        chk("clr_locked", int'(Locked), 0);
        chk("clr_bin", int'(Bin), 6);
        chk("clr_laps", int'(Laps), 1);
        drive(1'b1, 3'b011, 1'b0);
        after_edge();
        chk("relock", int'(Locked), 1);
        chk("relock_bin", int'(Bin), 2);

        // Reset landing on a Step_err pulse
        drive(1'b1, 3'b110, 1'b0);
        after_edge();
        chk("pulse_step", int'(Step_err), 1);
        #2 Reset = 1'b0;
        #1;
        chk("rst_pulse_step", int'(Step_err), 0);
        chk("rst_pulse_sticky", int'(Err_sticky), 0);
        chk("rst_pulse_laps", int'(Laps), 0);
        @(negedge Clk);
        Reset = 1'b1;
        Valid = 1'b0;

        // 256 wraps take Laps back to zero
        drive(1'b1, 3'b000, 1'b0);
        for (int w = 0; w < 256; w++) begin
            for (int k = 1; k < 8; k++) drive(1'b1, 3'(gseq[k]), 1'b0);
            drive(1'b1, 3'b000, 1'b0);
            if (w == 254) begin
                after_edge();
                chk("laps_255", int'(Laps), 255);
            end
        end
        after_edge();
        chk("laps_wrap0", int'(Laps), 0);
        drive(1'b1, 3'b001, 1'b0);
        after_edge();
        chk("pre_rst_bin", int'(Bin), 1);
        chk("pre_rst_locked", int'(Locked), 1);
        #3 Reset = 1'b0;
        #1;
        chk("async_bin", int'(Bin), 0);
        chk("async_laps", int'(Laps), 0);
        chk("async_locked", int'(Locked), 0);
        chk("async_step", int'(Step_err), 0);
        chk("async_sticky", int'(Err_sticky), 0);
        @(negedge Clk);
        Reset = 1'b1;
        Valid = 1'b0;
        drive(1'b0, 3'b000, 1'b0);
        @(negedge Clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The ports SHALL be exactly as follows (name  direction  width  meaning):
- Clk  input  1  single clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset.
- Valid  input  1  Gray is meaningful this cycle; driven from the upstream counter's enable.
- Gray  input  3  Gray code value from the upstream 3-bit Gray counter.
- Clr  input  1  synchronous clear of fault state.
- Bin  output  3  binary equivalent of the last accepted Gray sample.
- Laps  output  8  count of detected wraps, 100 -> 000.
- Locked  output  1  1 while the FSM is in LOCKED.
- Step_err  output  1  one-cycle pulse when an illegal transition is detected.
- Err_sticky  output  1  set on any illegal transition; held until Clr or reset.

Function
REQ-003 All outputs SHALL be registered; a sample taken on edge N SHALL appear on the outputs after edge N, giving 1-cycle latency.
REQ-004 Gray-to-binary conversion SHALL be as follows:
- b[2] = g[2].
- b[1] = g[2]^g[1].
- b[0] = b[1]^g[0].
REQ-005 The FSM SHALL have exactly three states: UNLOCKED, LOCKED and FAULT.
REQ-006 A cycle with Valid=0 SHALL leave state, Bin, Laps and Err_sticky unchanged, and Step_err SHALL be 0.
REQ-007 UNLOCKED with Valid=1: capture Gray as the previous sample, update Bin, go to LOCKED, perform no legality check.
REQ-008 LOCKED with Valid=1 SHALL classify the sample against the previous sample P:
- (a) HOLD: Gray==P. Legal, no change.
- (b) STEP: Gray==gray(bin(P)+1 mod 8). Legal.
- (c) WRAP: P==100 and Gray==000. Legal; Laps increments.
- (d) RESTART: Gray==000 and P!=100. Legal; Laps unchanged. This covers an upstream synchronous reset.
- (e) anything else is ILLEGAL.
REQ-009 In LOCKED, every legal sample (HOLD, STEP, WRAP, RESTART) SHALL update P and Bin.
REQ-010 In LOCKED, an ILLEGAL sample SHALL:
- update P and Bin;
- pulse Step_err=1 for exactly one cycle;
- set Err_sticky=1;
- move the FSM to FAULT.
REQ-011 FAULT with Valid=1: Bin and P keep tracking samples, no checks, no Laps update, no Step_err.
REQ-012 Clr=1 in any state SHALL clear Err_sticky, go to UNLOCKED, and take priority over a simultaneous Valid sample (the sample is discarded).
REQ-013 Clr SHALL NOT modify Laps or Bin.
REQ-014 Laps SHALL be 8-bit modulo: 255 + WRAP gives 0, with no saturation or flag.
REQ-015 Locked SHALL equal (state==LOCKED), registered.

Reset
REQ-016 When Reset=0, asynchronously and regardless of Clk, the block SHALL set:
- state = UNLOCKED;
- P = 000;
- Bin = 000;
- Laps = 0;
- Locked = 0;
- Step_err = 0;
- Err_sticky = 0.
REQ-017 Release of Reset mid-stream SHALL resume in UNLOCKED; the first Valid sample after release SHALL be accepted without check.
REQ-018 Reset asserted during a Step_err pulse SHALL force Step_err to 0 immediately.

Verification
REQ-019 Normal count: Valid=1, Gray 000,001,011,010,110,111,101,100,000 on successive cycles -> Bin 0..7 then 0, Laps=1, Locked=1 from the 2nd edge, Step_err never 1.
REQ-020 Hold: Valid toggles 1/0 with Gray frozen at 011 for 4 cycles -> Bin=2, no error, Laps unchanged.
REQ-021 Restart: LOCKED at Gray=110, then Gray=000 -> Bin=0, Laps unchanged, no error.
REQ-022 Illegal jump: LOCKED at 001, then 110 -> Step_err=1 for one cycle, Err_sticky=1, Locked=0, Bin=4; subsequent illegal samples raise no further Step_err.
REQ-023 Clr vs Valid: Clr=1 and Valid=1 (Gray=011) in the same cycle while in FAULT -> Err_sticky=0, UNLOCKED, Bin unchanged; the next Valid sample makes Locked=1.
REQ-024 Async reset: drive 256 wraps so that Laps=0 again (wraparound), then assert Reset=0 between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
